// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with wrap or saturate mode, clear/load/enable,
// combinational terminal count and registered overflow/underflow pulses.
module updown_counter_n #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  logic [WIDTH-1:0] count_r;
  logic             ovf_r;
  logic             udf_r;
  logic [WIDTH-1:0] count_next_s;
  logic             ovf_next_s;
  logic             udf_next_s;
  logic             at_max_s;
  logic             at_zero_s;

  assign at_max_s  = (count_r == MAX_C);
  assign at_zero_s = (count_r == ZERO_C);

  // Next-state selection: clr beats load beats en; boundary tested before stepping
  always_comb begin
    count_next_s = count_r;
    ovf_next_s   = 1'b0;
    udf_next_s   = 1'b0;
    if (clr) begin
      count_next_s = ZERO_C;
    end else if (load) begin
      count_next_s = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      if (up_down) begin
        if (at_max_s) begin
          ovf_next_s   = 1'b1;
          count_next_s = (SATURATE != 0) ? MAX_C : ZERO_C;
        end else begin
          count_next_s = count_r + ONE_C;
        end
      end else begin
        if (at_zero_s) begin
          udf_next_s   = 1'b1;
          count_next_s = (SATURATE != 0) ? ZERO_C : MAX_C;
        end else begin
          count_next_s = count_r - ONE_C;
        end
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // State and event-pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= ZERO_C;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      count_r <= count_next_s;
      ovf_r   <= ovf_next_s;
      udf_r   <= udf_next_s;
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;
  assign udf   = udf_r;
  assign tc    = (up_down & at_max_s) | (~up_down & at_zero_s);

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench for updown_counter_n: wrap (mod 10), saturate (mod 10)
// and full-range (mod 16) instances share one stimulus stream.
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       up_down = 1'b1;

  logic [3:0] count_a, count_s, count_f;
  logic       tc_a, tc_s, tc_f;
  logic       ovf_a, ovf_s, ovf_f;
  logic       udf_a, udf_s, udf_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_down(up_down), .count(count_a), .tc(tc_a), .ovf(ovf_a), .udf(udf_a));

  updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_down(up_down), .count(count_s), .tc(tc_s), .ovf(ovf_s), .udf(udf_s));

  updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_f (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_down(up_down), .count(count_f), .tc(tc_f), .ovf(ovf_f), .udf(udf_f));

  typedef struct packed {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       ovf;
    logic       udf;
    logic       tc;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vec [NVEC];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic l, input logic e, input logic u,
                      input logic [3:0] lv);
    clr = c; load = l; en = e; up_down = u; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // clr load en up lv | count ovf udf tc  (wrap instance, modulus 10)
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd6, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1};
    vec[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    vec[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
    vec[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    vec[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 1'b0};
    vec[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0};
    vec[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0};
    vec[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 4'd9, 1'b0, 1'b0, 1'b1};
    vec[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0};
    vec[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    vec[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    vec[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 1'b0};

    // Reset state
    #3;
    chk("rst_count", count_a, 4'd0);
    chk("rst_ovf", {3'd0, ovf_a}, 4'd0);
    chk("rst_udf", {3'd0, udf_a}, 4'd0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-count at 6
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    en = 1'b0;
    chk("pre_rst_count", count_a, 4'd6);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", count_a, 4'd0);
    chk("async_rst_ovf", {3'd0, ovf_a}, 4'd0);
    chk("async_rst_udf", {3'd0, udf_a}, 4'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    chk("post_rst_count", count_a, 4'd3);

    // Table-driven vectors on the wrap instance
    for (int i = 0; i < NVEC; i++) begin
      step(vec[i].clr, vec[i].load, vec[i].en, vec[i].up, vec[i].lv);
      chk($sformatf("vec%0d_count", i), count_a, vec[i].cnt);
      chk($sformatf("vec%0d_ovf", i), {3'd0, ovf_a}, {3'd0, vec[i].ovf});
      chk($sformatf("vec%0d_udf", i), {3'd0, udf_a}, {3'd0, vec[i].udf});
      chk($sformatf("vec%0d_tc", i), {3'd0, tc_a}, {3'd0, vec[i].tc});
    end

    // Saturate instance: load 8 then up 4 times
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
    chk("sat_load8", count_s, 4'd8);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      chk($sformatf("sat_up%0d_count", i), count_s, 4'd9);
      chk($sformatf("sat_up%0d_ovf", i), {3'd0, ovf_s}, (i == 0) ? 4'd0 : 4'd1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("sat_clr", count_s, 4'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      chk($sformatf("sat_dn%0d_count", i), count_s, 4'd0);
      chk($sformatf("sat_dn%0d_udf", i), {3'd0, udf_s}, 4'd1);
      chk($sformatf("sat_dn%0d_tc", i), {3'd0, tc_s}, 4'd1);
    end
    en = 1'b0;
    // Reset while a udf pulse is live must drop it without a clock edge
    #2 reset = 1'b0;
    #1;
    chk("sat_async_udf", {3'd0, udf_s}, 4'd0);
    #2 reset = 1'b1;

    // Full-range instance: natural binary roll-over
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("full_clr", count_f, 4'd0);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      chk($sformatf("full%0d_count", i), count_f, 4'((i + 1) % 16));
      chk($sformatf("full%0d_ovf", i), {3'd0, ovf_f}, (i == 15) ? 4'd1 : 4'd0);
    end
    chk("full_end", count_f, 4'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
    chk("full_load15", count_f, 4'd15);
    chk("full_tc", {3'd0, tc_f}, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
# updown_counter_n

Parametrised up/down counter, successor to the fixed 4-bit counter. It adds configurable width and modulus, wrap or saturate mode, synchronous clear/load/enable, a terminal-count flag and registered overflow/underflow event pulses. It is used as a general event/position counter in lab datapaths and as a divider/timebase when its terminal count drives other logic.

## Interface
- `WIDTH`, default 8: counter width in bits, ≥ 2.
- `MODULUS`, default 256: count range is 0..MODULUS-1. Must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.
- `SATURATE`, default 0: 0 selects wrap-around mode, 1 selects saturating mode.

- `clk` input, 1: clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low reset (asserted when 0).
- `en` input, 1: count enable.
- `clr` input, 1: synchronous clear to 0.
- `load` input, 1: synchronous load of `load_val`.
- `load_val` input, WIDTH: value to load.
- `up_down` input, 1: direction; 1 counts up, 0 counts down.
- `count` output, WIDTH: current count, registered.
- `tc` output, 1: terminal count, combinational from `count` and `up_down`.
- `ovf` output, 1: registered one-cycle pulse for an up-count attempted at MODULUS-1.
- `udf` output, 1: registered one-cycle pulse for a down-count attempted at 0.

## Operation
- Reset (`reset` = 0), asynchronous: `count` = 0, `ovf` = 0, `udf` = 0 immediately. The outputs hold these values while reset is asserted.
- Priority at each rising edge, highest first: `clr` > `load` > `en`. With none asserted, `count` holds.
- `clr`:
  - `count` ← 0.
  - `ovf`/`udf` ← 0.
- `load`:
  - `count` ← `load_val` when `load_val` ≤ MODULUS-1.
  - Otherwise `count` ← MODULUS-1, i.e. the value is clamped with no error flag.
  - `ovf`/`udf` ← 0.
- `en` with `up_down` = 1:
  - If `count` < MODULUS-1: `count` ← `count`+1.
  - If `count` = MODULUS-1: `ovf` ← 1. `count` ← 0 in wrap mode; `count` holds at MODULUS-1 in saturate mode.
- `en` with `up_down` = 0:
  - If `count` > 0: `count` ← `count`-1.
  - If `count` = 0: `udf` ← 1. `count` ← MODULUS-1 in wrap mode; `count` holds at 0 in saturate mode.
- `ovf`/`udf` are cleared on every edge that does not set them, so each pulse lasts exactly one cycle. They are never both high.
- `tc` = (`up_down` & `count` == MODULUS-1) | (!`up_down` & `count` == 0). It is valid regardless of `en`.
- Arithmetic:
  - The boundary compare is done before the increment/decrement, so no intermediate value outside 0..MODULUS-1 is ever registered.
  - When MODULUS = 2^WIDTH, wrap mode reduces to natural binary roll-over.
- `up_down` is sampled only at the clock edge. Changing it mid-cycle affects only the combinational `tc`.

## Timing
- Latency: control inputs take effect on `count` at the first rising edge where they are sampled. `ovf`/`udf` assert in the same edge as the boundary transition.
- Continuous `en` at constant direction produces one step per cycle. In wrap mode with up-count, `ovf` pulses every MODULUS cycles.
- Simultaneous events:
  - `clr` + `load` + `en`: the result is 0 and no pulse.
  - `load` + `en`: the loaded value wins; no step and no pulse that cycle.
- Reset mid-operation: `count`, `ovf` and `udf` go to 0 without waiting for a clock edge. The first edge after `reset` returns to 1 is processed normally.
- `tc` has no internal register. Its path is `count`/`up_down` through the comparators.

## Test plan
Parameters for these tests are WIDTH=4, MODULUS=10 unless stated otherwise.
- Reset: pulse `reset`=0 mid-count (`count`=6) between clock edges. Expect `count`=0 and `ovf`=`udf`=0 immediately. After release, `en`=1 and `up_down`=1 for 3 cycles gives `count`=3.
- Wrap, up: SATURATE=0, up-count from 0 for 12 cycles. Expect 0..9,0,1,2. `ovf` is high exactly for the cycle after 9→0, and `tc`=1 while `count`=9.
- Wrap, down: SATURATE=0, `load_val`=1, `load`, then down-count for 3 cycles. Expect 1,0,9,8. `udf` pulses once at 0→9, and `tc`=1 while `count`=0.
- Saturate: SATURATE=1, load 8, then up-count for 4 cycles. Expect 9,9,9,9 with `ovf` high on the 2nd, 3rd and 4th edges. Then down-count from 0 for 2 cycles: `count` stays at 0 and `udf` is high on both edges.
- Priority and clamp:
  - `clr`+`load`(`load_val`=5)+`en` in one cycle gives `count`=0.
  - `load`(`load_val`=15) gives `count`=9.
  - `load`(`load_val`=3)+`en` (up) gives `count`=3 with no `ovf`.
- Full range: WIDTH=4, MODULUS=16, SATURATE=0. Up-count for 17 cycles from 0. Expect roll-over 15→0 with one `ovf`, ending at `count`=1.
